// File: rtl/prog_ram_reader_if.sv
// Bundle of the program-RAM read port and the fetched-word valid/ready stream.
// The master side is the reader engine; the slave side is the RAM plus the consumer.
interface prog_ram_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              prog_cs_n;
    logic              prog_wd;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output prog_cs_n, prog_wd, prog_addr, out_valid, out_data, out_addr,
        input  prog_dout, out_ready
    );

    modport slave (
        input  prog_cs_n, prog_wd, prog_addr, out_valid, out_data, out_addr,
        output prog_dout, out_ready
    );
endinterface

// File: rtl/prog_ram_reader.sv
// Walks the program RAM from a start address, streaming each word out until END or the top address.
// Keeps a count and a 16-bit additive checksum of the accepted words.
module prog_ram_reader #(
    parameter int         ADDR_W      = 8,
    parameter int         DATA_W      = 16,
    parameter int         RD_LAT      = 1,
    parameter logic [3:0] END_OPCODE  = 4'b1100,
    parameter bit         STOP_ON_END = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic [DATA_W-1:0] checksum_o,
    prog_ram_reader_if.master bus
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DONE} state_e;

    state_e            state_q;
    logic              cs_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  lat_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] oaddr_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DATA_W-1:0] sum_q;
    logic              last_d;

    assign last_d = (STOP_ON_END && (data_q[DATA_W-1 -: 4] == END_OPCODE)) || (oaddr_q == '1);

    // WAIT runs RD_LAT cycles; chip select is released for the last one, while the
    // RAM output settles, so the select is low for exactly RD_LAT cycles per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            addr_q  <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            oaddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                cs_n_q  <= 1'b1;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            state_q <= S_FETCH;
                            addr_q  <= start_addr_i;
                            cnt_q   <= '0;
                            sum_q   <= '0;
                            cs_n_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_WAIT;
                        lat_q   <= CNT_W'(RD_LAT - 1);
                        cs_n_q  <= (RD_LAT == 1);
                    end
                    S_WAIT: begin
                        if (lat_q == '0) begin
                            state_q <= S_HOLD;
                            data_q  <= bus.prog_dout;
                            oaddr_q <= addr_q;
                            valid_q <= 1'b1;
                        end else begin
                            lat_q  <= lat_q - 1'b1;
                            cs_n_q <= (lat_q == CNT_W'(1));
                        end
                    end
                    S_HOLD: begin
                        if (bus.out_ready) begin
                            valid_q <= 1'b0;
                            cnt_q   <= cnt_q + 1'b1;
                            sum_q   <= sum_q + data_q;
                            if (last_d) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_FETCH;
                                addr_q  <= addr_q + 1'b1;
                                cs_n_q  <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.prog_cs_n = cs_n_q;
    assign bus.prog_wd   = 1'b0;
    assign bus.prog_addr = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = oaddr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign word_cnt_o    = cnt_q;
    assign checksum_o    = sum_q;
endmodule

// File: tb/tb_prog_ram_reader.sv
// Bench for prog_ram_reader: RD_LAT=1 instance for walks/abort/reset, RD_LAT=3 instance for latency.
// Expected words come from walking a shared RAM image in plain array arithmetic.
module tb_prog_ram_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];

    logic       start_a = 1'b0, abort_a = 1'b0, busy_a, done_a;
    logic [7:0] sa_a = '0;
    logic [8:0] wcnt_a;
    logic [15:0] sum_a;
    prog_ram_reader_if #(.ADDR_W(8), .DATA_W(16)) ifa ();

    logic       start_b = 1'b0, abort_b = 1'b0, busy_b, done_b;
    logic [7:0] sa_b = '0;
    logic [8:0] wcnt_b;
    logic [15:0] sum_b;
    prog_ram_reader_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

    prog_ram_reader #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .start_addr_i(sa_a),
        .busy_o(busy_a), .done_o(done_a), .word_cnt_o(wcnt_a), .checksum_o(sum_a), .bus(ifa));

    prog_ram_reader #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .start_addr_i(sa_b),
        .busy_o(busy_b), .done_o(done_b), .word_cnt_o(wcnt_b), .checksum_o(sum_b), .bus(ifb));

    // RAM models: address sampled while selected, data appears RD_LAT edges later
    logic [15:0] pa;
    logic [15:0] pb0, pb1, pb2;
    always_ff @(posedge clk) begin
        if (!ifa.prog_cs_n) pa <= mem[ifa.prog_addr];
        if (!ifb.prog_cs_n) pb0 <= mem[ifb.prog_addr];
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ifa.prog_dout = pa;
    assign ifb.prog_dout = pb2;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [23:0] exp_q [$];
    logic [15:0] exp_sum;

    // Reference walk: emit words from sa upward, stop after END opcode or address 255
    task automatic build_exp(input int sa);
        exp_q.delete();
        exp_sum = '0;
        for (int a = sa; a < 256; a++) begin
            exp_q.push_back({a[7:0], mem[a]});
            exp_sum = exp_sum + mem[a];
            if (mem[a][15:12] == 4'hC) break;
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 16'h2208; mem[1] = 16'h230C; mem[2] = 16'h4B00;
        mem[3] = 16'h8005; mem[4] = 16'hC000;
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, "_cs_n"}, ifa.prog_cs_n, 1'b1);
        check_eq({tag, "_wd"}, ifa.prog_wd, 1'b0);
        check_eq({tag, "_addr"}, ifa.prog_addr, 8'h00);
        check_eq({tag, "_valid"}, ifa.out_valid, 1'b0);
        check_eq({tag, "_data"}, ifa.out_data, 16'h0000);
        check_eq({tag, "_oaddr"}, ifa.out_addr, 8'h00);
        check_eq({tag, "_busy"}, busy_a, 1'b0);
        check_eq({tag, "_done"}, done_a, 1'b0);
        check_eq({tag, "_wcnt"}, wcnt_a, 9'd0);
        check_eq({tag, "_sum"}, sum_a, 16'h0000);
    endtask

    // mode 0: ready tied high, 1: ready low 3 cycles on word 2, 2: random ready
    task automatic walk_a(input string tag, input logic [7:0] sa, input int mode);
        int cyc = 0, idx = 0, stall_cnt = 0, first_lat = -1, last_hs = -1;
        bit prev_stall = 0, done_seen = 0, wrap = 0;
        logic [15:0] held = '0;
        build_exp(sa);
        @(negedge clk);
        start_a = 1'b1; sa_a = sa; ifa.out_ready = 1'b1;
        while (!done_seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (ifa.prog_addr < sa) wrap = 1;
            if (prev_stall) begin
                check_eq({tag, "_hold_valid"}, ifa.out_valid, 1'b1);
                check_eq({tag, "_hold_data"}, ifa.out_data, held);
            end
            if (ifa.out_valid) begin
                if (first_lat < 0) first_lat = cyc - 1;
                if (mode == 1 && idx == 2 && stall_cnt < 3) begin
                    ifa.out_ready = 1'b0; stall_cnt++;
                end else if (mode == 2) ifa.out_ready = ($urandom_range(0, 3) != 0);
                else ifa.out_ready = 1'b1;
                if (ifa.out_ready) begin
                    if (idx < exp_q.size()) begin
                        check_eq({tag, "_data"}, ifa.out_data, exp_q[idx][15:0]);
                        check_eq({tag, "_oaddr"}, ifa.out_addr, exp_q[idx][23:16]);
                    end else check_eq({tag, "_extra_word"}, idx, exp_q.size());
                    if (mode == 0 && last_hs >= 0) check_eq({tag, "_spacing"}, cyc - last_hs, 3);
                    last_hs = cyc;
                    idx++;
                end
                prev_stall = !ifa.out_ready;
                held = ifa.out_data;
            end else begin
                prev_stall = 0;
                ifa.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done_a) done_seen = 1;
        end
        check_eq({tag, "_done_seen"}, done_seen, 1'b1);
        check_eq({tag, "_words"}, idx, exp_q.size());
        check_eq({tag, "_wcnt"}, wcnt_a, exp_q.size());
        check_eq({tag, "_sum"}, sum_a, exp_sum);
        check_eq({tag, "_busy_done"}, busy_a, 1'b1);
        check_eq({tag, "_wrap"}, wrap, 1'b0);
        if (mode == 0) check_eq({tag, "_latency"}, first_lat, 2);
        if (mode == 1) check_eq({tag, "_stalls"}, stall_cnt, 3);
        @(negedge clk);
        check_eq({tag, "_busy_after"}, busy_a, 1'b0);
        check_eq({tag, "_done_pulse"}, done_a, 1'b0);
    endtask

    initial begin
        int cyc, seen, cs_cnt, first_lat;
        bit wd_bad, done_seen;
        ifa.out_ready = 1'b0;
        ifb.out_ready = 1'b1;
        load_image();
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        rst_n = 1'b1;

        walk_a("t1", 8'h00, 0);
        walk_a("t2", 8'h00, 1);

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hBFFF));
        walk_a("t3", 8'hFE, 0);

        // abort on the handshake cycle of word 1
        load_image();
        @(negedge clk);
        start_a = 1'b1; sa_a = 8'h00; ifa.out_ready = 1'b1;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (ifa.out_valid) seen++;
        end
        check_eq("t4_reached_word1", seen, 2);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_eq("t4_busy", busy_a, 1'b0);
        check_eq("t4_valid", ifa.out_valid, 1'b0);
        check_eq("t4_cs_n", ifa.prog_cs_n, 1'b1);
        check_eq("t4_done", done_a, 1'b0);
        check_eq("t4_wcnt", wcnt_a, 9'd1);
        check_eq("t4_sum", sum_a, 16'h2208);
        @(negedge clk);
        check_eq("t4_done_later", done_a, 1'b0);

        // start and abort together while idle
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check_eq("idle_abort_busy", busy_a, 1'b0);
        check_eq("idle_abort_cs_n", ifa.prog_cs_n, 1'b1);

        // RD_LAT=3 instance
        start_b = 1'b1; sa_b = 8'h03;
        build_exp(3);
        cyc = 0; seen = 0; cs_cnt = 0; first_lat = -1; wd_bad = 0; done_seen = 0;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_b = 1'b0;
            if (ifb.prog_wd !== 1'b0) wd_bad = 1;
            if (!ifb.prog_cs_n) cs_cnt++;
            if (ifb.out_valid) begin
                if (first_lat < 0) first_lat = cyc - 1;
                if (seen < exp_q.size()) check_eq("t5_data", ifb.out_data, exp_q[seen][15:0]);
                check_eq("t5_cs_cycles", cs_cnt, 3);
                cs_cnt = 0;
                seen++;
            end
            if (done_b) done_seen = 1;
        end
        check_eq("t5_done_seen", done_seen, 1'b1);
        check_eq("t5_latency", first_lat, 4);
        check_eq("t5_words", wcnt_b, exp_q.size());
        check_eq("t5_sum", sum_b, exp_sum);
        check_eq("t5_wd", wd_bad, 1'b0);

        // asynchronous reset in the middle of WAIT
        @(negedge clk);
        start_a = 1'b1; sa_a = 8'h01; ifa.out_ready = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        check_eq("t6_in_wait_busy", busy_a, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_a("t6");
        @(negedge clk);
        rst_n = 1'b1;
        walk_a("t6_rerun", 8'h00, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            walk_a("rand", 8'($urandom_range(0, 255)), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
